dmem_port: RTL and testbench

DMEM_PORT -- requirements
Module: dmem_port

---
 rtl/dmem_port.sv | 184 ++++++++++++++++++
 tb/tb_dmem_port.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port.sv
// Data-memory bus port: lane steering for stores, load extension, bus handshake with timeout.
// Optional DMEM_ALIGN_CHK_EN: misaligned half/word accesses complete at once with misalign=1.
module dmem_port #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dm_we,
  input  logic        dm_re,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wrbe,
  input  logic [2:0]  dmext_op,
  output logic [31:0] rdata_ext,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        misalign,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [2:0] OP_LB  = 3'd1;
  localparam logic [2:0] OP_LBU = 3'd2;
  localparam logic [2:0] OP_LH  = 3'd3;
  localparam logic [2:0] OP_LHU = 3'd4;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        mis_q, mis_d;

  logic        access_mis;
  logic        cnt_expired;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

`ifdef DMEM_ALIGN_CHK_EN
  // Byte accesses never misalign; anything that is not a byte/half load counts as a word load.
  always_comb begin
    access_mis = 1'b0;
    if (dm_we) begin
      access_mis = ((wrbe == 4'b0011) && addr[0]) ||
                   ((wrbe == 4'b1111) && (addr[1:0] != 2'b00));
    end else begin
      case (dmext_op)
        OP_LB, OP_LBU: access_mis = 1'b0;
        OP_LH, OP_LHU: access_mis = addr[0];
        default:       access_mis = (addr[1:0] != 2'b00);
      endcase
    end
  end
`else
  assign access_mis = 1'b0;
`endif

  always_comb begin
    ld_byte = bus_rdata[7:0];
    case (addr_q[1:0])
      2'd0: ld_byte = bus_rdata[7:0];
      2'd1: ld_byte = bus_rdata[15:8];
      2'd2: ld_byte = bus_rdata[23:16];
      2'd3: ld_byte = bus_rdata[31:24];
      default: ld_byte = bus_rdata[7:0];
    endcase
    ld_half = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (op_q)
      OP_LB:   ld_ext = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_ext = {24'd0, ld_byte};
      OP_LH:   ld_ext = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_ext = {16'd0, ld_half};
      default: ld_ext = bus_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    op_d        = op_q;
    rdata_d     = rdata_q;
    err_d       = 1'b0;
    mis_d       = 1'b0;
    cnt_expired = (cnt_q == CNT_LAST);

    case (state_q)
      S_IDLE: begin
        if (dm_we || dm_re) begin
          // A simultaneous store and load strobe is treated as a store.
          we_d    = dm_we;
          addr_d  = addr;
          op_d    = dmext_op;
          be_d    = dm_we ? 4'(wrbe << addr[1:0]) : 4'b1111;
          wdata_d = dm_we ? (wdata << {addr[1:0], 3'b000}) : 32'd0;
          cnt_d   = 8'd0;
          if (access_mis) begin
            state_d = S_DONE;
            mis_d   = 1'b1;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (bus_gnt) begin
          state_d = we_q ? S_DONE : S_RESP;
        end else if (cnt_expired) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
      end
      S_RESP: begin
        cnt_d = cnt_q + 8'd1;
        if (bus_rvalid) begin
          rdata_d = ld_ext;
          state_d = S_DONE;
        end else if (cnt_expired) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      op_q    <= 3'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
    end
  end

  assign busy      = (state_q == S_REQ) || (state_q == S_RESP);
  assign bus_req   = (state_q == S_REQ);
  assign bus_we    = (state_q == S_REQ) && we_q;
  assign bus_addr  = {addr_q[31:2], 2'b00};
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign misalign  = mis_q;
  assign rdata_ext = rdata_q;

endmodule

// File: tb/tb_dmem_port.sv
// Scoreboard bench for dmem_port: expected access records are queued, then compared per access.
module tb_dmem_port;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dm_we, dm_re;
  logic [31:0] addr, wdata;
  logic [3:0]  wrbe;
  logic [2:0]  dmext_op;
  logic [31:0] rdata_ext;
  logic        busy, done, err, misalign;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;

  always #5 clk = ~clk;

  dmem_port #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .dm_we(dm_we), .dm_re(dm_re), .addr(addr), .wdata(wdata),
    .wrbe(wrbe), .dmext_op(dmext_op), .rdata_ext(rdata_ext), .busy(busy), .done(done),
    .err(err), .misalign(misalign), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata)
  );

  typedef struct packed {
    logic        req_seen;
    logic [7:0]  req_k;
    logic [31:0] baddr;
    logic [3:0]  be;
    logic [31:0] bwdata;
    logic        bwe;
    logic        unstable;
    logic [7:0]  done_k;
    logic        err;
    logic        mis;
    logic [31:0] rext;
    logic [7:0]  extra;
  } obs_t;

  obs_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_rext = 32'd0;

  function automatic obs_t mk(input logic rs, input logic [31:0] ba, input logic [3:0] be,
                              input logic [31:0] wd, input logic we, input int dk,
                              input logic er, input logic mi, input logic [31:0] rx);
    obs_t e = '0;
    e.req_seen = rs;
    e.req_k    = rs ? 8'd1 : 8'd0;
    e.baddr    = ba;
    e.be       = be;
    e.bwdata   = wd;
    e.bwe      = we;
    e.done_k   = 8'(dk);
    e.err      = er;
    e.mis      = mi;
    e.rext     = rx;
    return e;
  endfunction

  // Reference model for handshake-complete accesses (delays well below the timeout).
  function automatic obs_t model(input logic we, input logic [31:0] a, input logic [31:0] wd,
                                 input logic [3:0] mask, input logic [2:0] op,
                                 input logic [31:0] rd, input int gd, input int rvd,
                                 input logic [31:0] prev);
    obs_t        e = '0;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] x;
    logic        mi = 1'b0;
    b = 8'(rd >> (8 * a[1:0]));
    h = 16'(rd >> (16 * a[1]));
    case (op)
      3'd1:    x = {{24{b[7]}}, b};
      3'd2:    x = {24'd0, b};
      3'd3:    x = {{16{h[15]}}, h};
      3'd4:    x = {16'd0, h};
      default: x = rd;
    endcase
`ifdef DMEM_ALIGN_CHK_EN
    if (we) mi = (mask == 4'b0011 && a[0]) || (mask == 4'b1111 && a[1:0] != 2'b00);
    else    mi = ((op == 3'd3 || op == 3'd4) && a[0]) ||
                 (!(op inside {3'd1, 3'd2, 3'd3, 3'd4}) && a[1:0] != 2'b00);
`endif
    if (mi) e = mk(1'b0, 32'd0, 4'd0, 32'd0, 1'b0, 1, 1'b0, 1'b1, prev);
    else if (we) e = mk(1'b1, {a[31:2], 2'b00}, 4'({4'd0, mask} << a[1:0]),
                        wd << (8 * a[1:0]), 1'b1, 2 + gd, 1'b0, 1'b0, prev);
    else e = mk(1'b1, {a[31:2], 2'b00}, 4'b1111, 32'd0, 1'b0, 3 + gd + rvd, 1'b0, 1'b0, x);
    return e;
  endfunction

  // Drives one access from the IDLE cycle and records what the DUT did; no judgement here.
  task automatic run_access(input logic we, input logic re, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] mask, input logic [2:0] op,
                            input logic [31:0] rd, input int gnt_dly, input int rv_dly,
                            input int n_post, input bit stray, output obs_t o);
    int req_cnt = 0;
    int resp_cnt = 0;
    o = '0;
    dm_we = we; dm_re = re; addr = a; wdata = wd; wrbe = mask; dmext_op = op; bus_rdata = rd;
    @(posedge clk); #1;
    for (int k = 1; k <= 60; k++) begin
      if (stray && k == 2) begin
        dm_we = 1'b1; dm_re = 1'b1; addr = 32'h0000_0F00;
      end else begin
        dm_we = 1'b0; dm_re = 1'b0;
      end
      bus_gnt    = bus_req && (req_cnt >= gnt_dly);
      bus_rvalid = busy && !bus_req && (resp_cnt >= rv_dly);
      @(negedge clk);
      if (bus_req) begin
        if (!o.req_seen) begin
          o.req_seen = 1'b1; o.req_k = 8'(k); o.baddr = bus_addr; o.be = bus_be;
          o.bwe = bus_we; o.bwdata = bus_we ? bus_wdata : 32'd0;
        end else if (bus_addr !== o.baddr || bus_be !== o.be || bus_we !== o.bwe ||
                     (bus_we && bus_wdata !== o.bwdata)) begin
          o.unstable = 1'b1;
        end
        req_cnt++;
      end else if (busy) begin
        resp_cnt++;
      end
      if (done) begin
        o.done_k = 8'(k); o.err = err; o.mis = misalign; o.rext = rdata_ext;
        break;
      end
      @(posedge clk); #1;
    end
    dm_we = 1'b0; dm_re = 1'b0;
    // Late grant/rvalid while idle must not start or complete anything.
    for (int p = 0; p < n_post; p++) begin
      @(posedge clk); #1;
      bus_gnt = 1'b1; bus_rvalid = 1'b1;
      @(negedge clk);
      if (done || busy || bus_req || rdata_ext !== o.rext) o.extra++;
    end
    @(posedge clk); #1;
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({bus_req, busy, done, err, misalign, bus_we, bus_addr, bus_be, bus_wdata, rdata_ext} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got req=%b busy=%b done=%b err=%b mis=%b we=%b addr=%h be=%b wd=%h rx=%h want all 0",
               bus_req, busy, done, err, misalign, bus_we, bus_addr, bus_be, bus_wdata, rdata_ext);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_store_sb();
    obs_t o, e;
    sb.push_back(mk(1'b1, 32'h100, 4'b1000, 32'hA500_0000, 1'b1, 2, 1'b0, 1'b0, last_rext));
    run_access(1'b1, 1'b0, 32'h103, 32'h0000_00A5, 4'b0001, 3'd0, 32'd0, 0, 0, 3, 1'b1, o);
    e = sb.pop_front();
    n_vec++;
    if (o !== e) begin
      n_err++;
      $display("FAIL store_sb: got %h want %h", o, e);
    end
    last_rext = e.rext;
  endtask

  task automatic test_load_ext();
    logic [31:0] t_a[4]  = '{32'h202, 32'h202, 32'h2, 32'h2};
    logic [31:0] t_rd[4] = '{32'h12F0_3456, 32'h12F0_3456, 32'h8001_FFFF, 32'h8001_FFFF};
    logic [2:0]  t_op[4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    int          t_rv[4] = '{2, 2, 0, 0};
    int          t_dk[4] = '{5, 5, 3, 3};
    logic [31:0] t_x[4]  = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_8001, 32'h0000_8001};
    obs_t o, e;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(mk(1'b1, {t_a[i][31:2], 2'b00}, 4'b1111, 32'd0, 1'b0, t_dk[i], 1'b0, 1'b0, t_x[i]));
      run_access(1'b0, 1'b1, t_a[i], 32'hFFFF_FFFF, 4'b1111, t_op[i], t_rd[i], 0, t_rv[i], 3, 1'b0, o);
      e = sb.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL load_ext[%0d]: got %h want %h", i, o, e);
      end
      last_rext = e.rext;
    end
  endtask

  task automatic test_store_hold();
    obs_t o, e;
    sb.push_back(mk(1'b1, 32'h20, 4'b1111, 32'hDEAD_BEEF, 1'b1, 4, 1'b0, 1'b0, last_rext));
    run_access(1'b1, 1'b0, 32'h20, 32'hDEAD_BEEF, 4'b1111, 3'd1, 32'h7777_7777, 2, 0, 2, 1'b0, o);
    e = sb.pop_front();
    n_vec++;
    if (o !== e) begin
      n_err++;
      $display("FAIL store_hold: got %h want %h", o, e);
    end
  endtask

  task automatic test_timeout();
    obs_t o, e;
    sb.push_back(mk(1'b1, 32'h40, 4'b1111, 32'd0, 1'b0, TIMEOUT + 1, 1'b1, 1'b0, last_rext));
    run_access(1'b0, 1'b1, 32'h40, 32'd0, 4'b1111, 3'd0, 32'h1234_5678, 1000, 0, 3, 1'b1, o);
    e = sb.pop_front();
    n_vec++;
    if (o !== e) begin
      n_err++;
      $display("FAIL timeout_req: got %h want %h", o, e);
    end
    // Counter keeps running across REQ->RESP: grant after 5 waits, rvalid never comes.
    sb.push_back(mk(1'b1, 32'h44, 4'b1111, 32'd0, 1'b0, TIMEOUT + 1, 1'b1, 1'b0, last_rext));
    run_access(1'b0, 1'b1, 32'h44, 32'd0, 4'b1111, 3'd0, 32'h1234_5678, 5, 1000, 3, 1'b0, o);
    e = sb.pop_front();
    n_vec++;
    if (o !== e) begin
      n_err++;
      $display("FAIL timeout_resp: got %h want %h", o, e);
    end
  endtask

  task automatic test_both_strobes();
    obs_t o, e;
    sb.push_back(mk(1'b1, 32'h10, 4'b1111, 32'h1122_3344, 1'b1, 2, 1'b0, 1'b0, last_rext));
    run_access(1'b1, 1'b1, 32'h10, 32'h1122_3344, 4'b1111, 3'd1, 32'h9999_9999, 0, 0, 2, 1'b0, o);
    e = sb.pop_front();
    n_vec++;
    if (o !== e) begin
      n_err++;
      $display("FAIL both_strobes: got %h want %h", o, e);
    end
  endtask

  task automatic test_align();
    obs_t o, e;
`ifdef DMEM_ALIGN_CHK_EN
    e = mk(1'b0, 32'd0, 4'd0, 32'd0, 1'b0, 1, 1'b0, 1'b1, last_rext);
`else
    e = mk(1'b1, 32'h4, 4'b1111, 32'd0, 1'b0, 3, 1'b0, 1'b0, 32'hCAFE_F00D);
`endif
    sb.push_back(e);
    run_access(1'b0, 1'b1, 32'h6, 32'd0, 4'b1111, 3'd0, 32'hCAFE_F00D, 0, 0, 3, 1'b0, o);
    e = sb.pop_front();
    n_vec++;
    if (o !== e) begin
      n_err++;
      $display("FAIL align_lw6: got %h want %h", o, e);
    end
    last_rext = e.rext;
  endtask

  task automatic test_back_to_back();
    logic [3:0] masks[3] = '{4'b0001, 4'b0011, 4'b1111};
    obs_t o, e;
    for (int i = 0; i < 10; i++) begin
      logic        we  = 1'($urandom_range(0, 1));
      logic [31:0] a   = $urandom;
      logic [31:0] wd  = $urandom;
      logic [31:0] rd  = $urandom;
      logic [3:0]  m   = masks[$urandom_range(0, 2)];
      logic [2:0]  op  = 3'($urandom_range(0, 7));
      int          gd  = $urandom_range(0, 3);
      int          rvd = $urandom_range(0, 3);
      sb.push_back(model(we, a, wd, m, op, rd, gd, rvd, last_rext));
      run_access(we, !we, a, wd, m, op, rd, gd, rvd, 0, 1'b0, o);
      e = sb.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL back_to_back[%0d] we=%b a=%h op=%0d: got %h want %h", i, we, a, op, o, e);
      end
      last_rext = e.rext;
    end
  endtask

  task automatic test_reset_mid();
    int dcnt = 0;
    dm_re = 1'b1; dm_we = 1'b0; addr = 32'h80; dmext_op = 3'd0; bus_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    dm_re = 1'b0; bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    n_vec++;
    if ({busy, bus_req} !== 2'b10) begin
      n_err++;
      $display("FAIL reset_mid_in_resp: got busy=%b req=%b want busy=1 req=0", busy, bus_req);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if ({busy, bus_req} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_mid_immediate: got busy=%b req=%b want 0 0", busy, bus_req);
    end
    repeat (3) begin
      @(negedge clk);
      dcnt += int'(done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    dcnt += int'(done);
    n_vec++;
    if (dcnt !== 0) begin
      n_err++;
      $display("FAIL reset_mid_no_done: got %0d done pulses want 0", dcnt);
    end
    n_vec++;
    if ({bus_req, busy, done, err, misalign, bus_we, bus_addr, bus_be, bus_wdata, rdata_ext} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_outputs: got addr=%h be=%b wd=%h rx=%h busy=%b want all 0",
               bus_addr, bus_be, bus_wdata, rdata_ext, busy);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    dm_we = 1'b0; dm_re = 1'b0; addr = 32'd0; wdata = 32'd0; wrbe = 4'd0; dmext_op = 3'd0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
    test_reset();
    test_store_sb();
    test_load_ext();
    test_store_hold();
    test_timeout();
    test_both_strobes();
    test_align();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
